stage_ma: RTL

Memory-access pipeline stage that sits between the execute stage and stage_mawb, and drives stage_mawb's input bundle.
- Takes the EX/MA bundle: ALU result/address, store data, memory-op controls and writeback controls.
- Performs the load/store on a req/ack data-memory port, holding the pipeline with a stall while the access is outstanding.
- Aligns, sign- or zero-extends load data and forwards the registered result with a valid strobe (ena_mawb_out).
- Detects misaligned, illegal-size and timed-out accesses, and reports them as exceptions.

---
 rtl/riscv_pkg.sv | 43 ++++
 rtl/stage_ma_lsu_align.sv | 49 ++++
 rtl/stage_ma.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I encodings used by the memory-access stage: load/store funct3,
// exception causes, writeback source selects and the stage FSM state type.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_BUSTO    = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

  localparam logic [1:0] WRN_ALU = 2'b00;
  localparam logic [1:0] WRN_MEM = 2'b01;
  localparam logic [1:0] WRN_PC4 = 2'b10;
  localparam logic [1:0] WRN_CSR = 2'b11;

  typedef enum logic {
    MA_IDLE = 1'b0,
    MA_WAIT = 1'b1
  } ma_state_e;

  function automatic logic load_f3_legal(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic store_f3_legal(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

  // Size lives in funct3[1:0]; bytes can never be misaligned.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/stage_ma_lsu_align.sv
// Lane steering for the data-memory port: byte enables and replicated store
// data on the request side, lane select plus sign/zero extension on the load side.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] lane_w;

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = st_data_i;
    case (st_funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << st_off_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      2'b01: begin
        be_o    = st_off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{st_data_i[15:0]}};
      end
      2'b10:   be_o = 4'b1111;
      default: be_o = 4'b0000;
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend by access type.
  always_comb begin
    lane_w    = rdata_i >> {ld_off_i, 3'b000};
    ld_data_o = lane_w;
    case (ld_funct3_i)
      F3_LB:   ld_data_o = {{24{lane_w[7]}}, lane_w[7:0]};
      F3_LH:   ld_data_o = {{16{lane_w[15]}}, lane_w[15:0]};
      F3_LBU:  ld_data_o = {24'h0, lane_w[7:0]};
      F3_LHU:  ld_data_o = {16'h0, lane_w[15:0]};
      default: ld_data_o = lane_w;
    endcase
  end

endmodule

// File: rtl/stage_ma.sv
// Memory-access pipeline stage: issues loads/stores on a req/ack port, stalls
// upstream while waiting, and registers the bundle (or an exception) for stage_mawb.
module stage_ma
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES  = 255,
  parameter bit          RESET_ADDR_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] busc_in,
  input  logic [31:0] busb_in,
  input  logic        mem_rd_in,
  input  logic        mem_wr_in,
  input  logic [2:0]  funct3_in,
  input  logic        write_ena_in,
  input  logic [4:0]  rd_in,
  input  logic [1:0]  wrn_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        ena_mawb_out,
  output logic [31:0] data_out,
  output logic [31:0] busc_out,
  output logic        write_ena_out,
  output logic [4:0]  rd_out,
  output logic [1:0]  wrn_out,
  output logic        exc_out,
  output logic [1:0]  exc_cause_out,
  output logic [31:0] exc_addr_out
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  ma_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        is_ld_q, is_ld_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] pbusc_q, pbusc_d;
  logic        pwe_q, pwe_d;
  logic [4:0]  prd_q, prd_d;
  logic [1:0]  pwrn_q, pwrn_d;
  logic        ena_q, ena_d, wen_q, wen_d, exc_q, exc_d;
  logic [31:0] data_q, data_d, busc_q, busc_d, exc_addr_q, exc_addr_d;
  logic [4:0]  rd_q, rd_d;
  logic [1:0]  wrn_q, wrn_d, cause_q, cause_d;

  logic        is_mem, is_illegal, is_misalign;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;

  lsu_align u_align (
    .st_funct3_i (funct3_in),
    .st_off_i    (busc_in[1:0]),
    .st_data_i   (busb_in),
    .be_o        (st_be),
    .wdata_o     (st_wdata),
    .ld_funct3_i (f3_q),
    .ld_off_i    (off_q),
    .rdata_i     (dmem_rdata),
    .ld_data_o   (ld_data)
  );

  always_comb begin
    is_mem      = mem_rd_in | mem_wr_in;
    is_illegal  = (mem_rd_in && mem_wr_in) ||
                  (mem_rd_in && !load_f3_legal(funct3_in)) ||
                  (mem_wr_in && !store_f3_legal(funct3_in));
    is_misalign = is_misaligned(funct3_in, busc_in[1:0]);
  end

  // Output bundle defaults to a bubble every cycle; only the cases below fill it.
  always_comb begin
    state_d = state_q;   cnt_d   = cnt_q;
    req_d   = req_q;     we_d    = we_q;     addr_d  = addr_q;
    be_d    = be_q;      wdata_d = wdata_q;
    is_ld_d = is_ld_q;   f3_d    = f3_q;     off_d   = off_q;
    pbusc_d = pbusc_q;   pwe_d   = pwe_q;    prd_d   = prd_q;   pwrn_d = pwrn_q;
    ena_d   = 1'b0;      data_d  = '0;       busc_d  = '0;
    wen_d   = 1'b0;      rd_d    = '0;       wrn_d   = '0;
    exc_d   = 1'b0;      cause_d = EXC_NONE; exc_addr_d = exc_addr_q;
    case (state_q)
      MA_IDLE: begin
        if (valid_in) begin
          if (!is_mem) begin
            ena_d  = 1'b1;
            busc_d = busc_in;
            wen_d  = write_ena_in;
            rd_d   = rd_in;
            wrn_d  = wrn_in;
          end else if (is_illegal || is_misalign) begin
            exc_d      = 1'b1;
            cause_d    = is_illegal ? EXC_ILLEGAL : EXC_MISALIGN;
            exc_addr_d = busc_in;
          end else begin
            state_d = MA_WAIT;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = mem_wr_in;
            addr_d  = {busc_in[31:2], 2'b00};
            be_d    = st_be;
            wdata_d = mem_wr_in ? st_wdata : '0;
            is_ld_d = mem_rd_in;
            f3_d    = funct3_in;
            off_d   = busc_in[1:0];
            pbusc_d = busc_in;
            pwe_d   = write_ena_in;
            prd_d   = rd_in;
            pwrn_d  = wrn_in;
          end
        end
      end
      MA_WAIT: begin
        if (dmem_ack) begin
          state_d = MA_IDLE;
          req_d   = 1'b0;
          ena_d   = 1'b1;
          data_d  = is_ld_q ? ld_data : '0;
          busc_d  = pbusc_q;
          wen_d   = pwe_q;
          rd_d    = prd_q;
          wrn_d   = pwrn_q;
        end else if (cnt_q == TO_LAST) begin
          state_d    = MA_IDLE;
          req_d      = 1'b0;
          exc_d      = 1'b1;
          cause_d    = EXC_BUSTO;
          exc_addr_d = addr_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = MA_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MA_IDLE;  cnt_q   <= '0;
      req_q   <= 1'b0;     we_q    <= 1'b0;   addr_q <= '0;
      be_q    <= '0;       wdata_q <= '0;
      is_ld_q <= 1'b0;     f3_q    <= '0;     off_q  <= '0;
      pbusc_q <= '0;       pwe_q   <= 1'b0;   prd_q  <= '0;   pwrn_q <= '0;
      ena_q   <= 1'b0;     data_q  <= '0;     busc_q <= '0;
      wen_q   <= 1'b0;     rd_q    <= '0;     wrn_q  <= '0;
      exc_q   <= 1'b0;     cause_q <= EXC_NONE;
    end else begin
      state_q <= state_d;  cnt_q   <= cnt_d;
      req_q   <= req_d;    we_q    <= we_d;   addr_q <= addr_d;
      be_q    <= be_d;     wdata_q <= wdata_d;
      is_ld_q <= is_ld_d;  f3_q    <= f3_d;   off_q  <= off_d;
      pbusc_q <= pbusc_d;  pwe_q   <= pwe_d;  prd_q  <= prd_d;  pwrn_q <= pwrn_d;
      ena_q   <= ena_d;    data_q  <= data_d; busc_q <= busc_d;
      wen_q   <= wen_d;    rd_q    <= rd_d;   wrn_q  <= wrn_d;
      exc_q   <= exc_d;    cause_q <= cause_d;
    end
  end

  // The faulting address can optionally survive reset for post-mortem reads.
  generate
    if (RESET_ADDR_ZERO) begin : g_addr_rst
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) exc_addr_q <= '0;
        else        exc_addr_q <= exc_addr_d;
      end
    end else begin : g_addr_hold
      always_ff @(posedge clk) exc_addr_q <= exc_addr_d;
    end
  endgenerate

  assign stall_out     = (state_q == MA_WAIT);
  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_be       = be_q;
  assign dmem_wdata    = wdata_q;
  assign ena_mawb_out  = ena_q;
  assign data_out      = data_q;
  assign busc_out      = busc_q;
  assign write_ena_out = wen_q;
  assign rd_out        = rd_q;
  assign wrn_out       = wrn_q;
  assign exc_out       = exc_q;
  assign exc_cause_out = cause_q;
  assign exc_addr_out  = exc_addr_q;

endmodule
